mimo_decode_sequencer: RTL and testbench
========================================

# mimo_decode_sequencer

Front-end controller for the 4x4 8-PSK K-best decoder core. It accepts channel-matrix rows and received-symbol vectors from upstream over a valid/ready stream. It buffers the four channel rows and bursts them into the core on consecutive cycles with the channel/data flag high. It then issues data vectors one at a time, holds each for the core's fixed decode latency, and captures the decoded symbols into a valid/ready output register.

## Interface
- W_L, 15: input sample width (signed, per real/imag component)
- W_O, 15: decoded-output field width
- DEC_LAT, 36: cycles each data vector must be held on the core input; legal range ≥ 2
- NUM_VEC, 11: data vectors per channel realization; legal range ≥ 1
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- s_valid  in  1  upstream beat valid
- s_ready  out  1  upstream beat accepted when s_valid && s_ready
- s_data  in  8*W_L  channel row (CH_FILL) or received vector re/im x4 (DATA_WAIT)
- dec_flag  out  1  to core flagChannelorData; 1 = channel beat, 0 = data
- dec_data  out  8*W_L  to core InData
- dec_out  in  8*W_O  from core OutData
- m_valid  out  1  decoded vector valid
- m_ready  in  1  downstream accept
- m_data  out  8*W_O  decoded vector
- busy  out  1  high in every state except DATA_WAIT with vec_cnt == 0

## Operation
- FSM states: CH_FILL, CH_BURST, DATA_WAIT, DATA_RUN. Reset state is CH_FILL.
- CH_FILL
  - s_ready = 1.
  - Each handshake writes s_data into ch_buf[row_cnt] and increments row_cnt (2 bits).
  - The 4th accepted beat goes to CH_BURST with burst_cnt = 0.
- CH_BURST
  - s_ready = 0.
  - Each cycle: dec_flag = 1, dec_data = ch_buf[burst_cnt], burst_cnt++.
  - Runs exactly 4 cycles, then goes to DATA_WAIT with vec_cnt = 0.
- DATA_WAIT
  - s_ready = !m_valid || m_ready, so the output register is guaranteed free at capture.
  - On handshake: dec_data <= s_data, dec_flag <= 0, lat_cnt <= 0, go to DATA_RUN.
- DATA_RUN
  - s_ready = 0. dec_data and dec_flag are held. lat_cnt increments.
  - When lat_cnt == DEC_LAT-1: m_data <= dec_out, m_valid <= 1, vec_cnt++.
  - Next state: CH_FILL if vec_cnt was NUM_VEC-1 (row_cnt cleared), else DATA_WAIT.
- Output register
  - m_valid clears on m_valid && m_ready unless a capture occurs in the same cycle; capture wins and sets m_valid.
- Widths
  - lat_cnt: $clog2(DEC_LAT) bits.
  - vec_cnt: $clog2(NUM_VEC+1) bits.
  - No arithmetic on data; all paths are pure transport.
- dec_flag returns to 1 only on entry to CH_BURST. Between frames (CH_FILL) it keeps its last value 0.

## Timing
- Reset values:
  - state = CH_FILL; s_ready = 1 after reset release.
  - dec_flag = 1, dec_data = 0.
  - m_valid = 0, m_data = 0, busy = 1.
  - All counters and ch_buf = 0.
- Channel path: 4th beat accepted at cycle T → burst on dec_data in cycles T+1..T+4 → DATA_WAIT at T+5.
- Data path: vector accepted at T → dec_data valid T+1..T+DEC_LAT → m_valid high from T+DEC_LAT+1.
- Throughput: one vector per DEC_LAT+1 cycles with no backpressure.
- Outputs are registered except s_ready and busy, which are decoded from state and m_valid.
- Reset asserted mid-frame aborts immediately. A partially loaded channel is discarded and a pending m_valid is dropped.

## Configuration
- MIMO_SEQ_STATS_EN defined: adds two outputs.
  - vec_total: 16-bit saturating count of captured vectors.
  - stall_cycles: 16-bit saturating count of DATA_WAIT cycles with s_valid=1 && s_ready=0.
  - Both reset to 0.
- Undefined: neither port nor counter exists. Behaviour is otherwise identical.

## Structure
- Shared package mimo_dec_pkg holds:
  - state enum seq_state_t
  - W_L / W_O defaults
  - CH_ROWS = 4 constant
  - the lane-slicing functions for the 8 re/im fields
- One sub-module: mimo_ch_buf, a 4 x 8*W_L register file with write port (we, waddr) and read port (raddr).

## Test plan
- Reset release, then 4 channel beats on consecutive cycles → dec_flag = 1 and dec_data equals beats 0..3 in order on 4 consecutive cycles. s_ready = 0 during the burst.
- Channel beats with s_valid gaps (1 cycle idle between each) → burst is still 4 back-to-back cycles. First data beat is accepted no earlier than burst end + 1.
- Data vector accepted at T with DEC_LAT=36 → dec_data is stable for cycles T+1..T+36; m_valid rises at T+37 with m_data = dec_out sampled at T+36.
- NUM_VEC=2, m_ready held 0 → second vector is not accepted while m_valid=1. Raising m_ready accepts the second vector that same cycle. After its capture the FSM returns to CH_FILL (s_ready = 1, busy = 1).
- Reset asserted on lat_cnt = 20 → m_valid = 0 and dec_flag = 1 immediately. After release the FSM needs 4 fresh channel beats before any data is accepted.
- With MIMO_SEQ_STATS_EN: 3 vectors decoded and 5 stalled-valid cycles → vec_total = 3, stall_cycles = 5.

Source files
------------

// File: rtl/mimo_dec_pkg.sv
// Shared types and constants for the 4x4 8-PSK K-best decoder front-end sequencer.
package mimo_dec_pkg;

    typedef enum logic [1:0] {
        CH_FILL   = 2'd0,
        CH_BURST  = 2'd1,
        DATA_WAIT = 2'd2,
        DATA_RUN  = 2'd3
    } seq_state_t;

    localparam int unsigned W_L_DEF = 15;
    localparam int unsigned W_O_DEF = 15;
    localparam int unsigned CH_ROWS = 4;
    localparam int unsigned FIELDS  = 8;

    // Antenna k occupies field 2k (real) and field 2k+1 (imag), LSB first.
    function automatic logic [W_L_DEF-1:0] lane_re(input logic [FIELDS*W_L_DEF-1:0] v,
                                                   input int unsigned k);
        return v[(2*k)*W_L_DEF +: W_L_DEF];
    endfunction

    function automatic logic [W_L_DEF-1:0] lane_im(input logic [FIELDS*W_L_DEF-1:0] v,
                                                   input int unsigned k);
        return v[(2*k+1)*W_L_DEF +: W_L_DEF];
    endfunction

endpackage

// File: rtl/mimo_ch_buf.sv
// Four-row channel-matrix register file: one write port, one combinational read port.
module mimo_ch_buf
    import mimo_dec_pkg::*;
#(
    parameter int unsigned DW = FIELDS * W_L_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [1:0]    waddr,
    input  logic [DW-1:0] wdata,
    input  logic [1:0]    raddr,
    output logic [DW-1:0] rdata_c
);

    logic [DW-1:0] mem_q [CH_ROWS];
    logic [DW-1:0] mem_d [CH_ROWS];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < CH_ROWS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata_c = mem_q[raddr];

endmodule

// File: rtl/mimo_decode_sequencer.sv
// Front-end sequencer for the K-best MIMO decoder core: channel load/burst, then timed data decode.
// Optional MIMO_SEQ_STATS_EN adds saturating vec_total / stall_cycles counters.
module mimo_decode_sequencer
    import mimo_dec_pkg::*;
#(
    parameter int unsigned W_L     = W_L_DEF,
    parameter int unsigned W_O     = W_O_DEF,
    parameter int unsigned DEC_LAT = 36,
    parameter int unsigned NUM_VEC = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [8*W_L-1:0] s_data,
    output logic             dec_flag,
    output logic [8*W_L-1:0] dec_data,
    input  logic [8*W_O-1:0] dec_out,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [8*W_O-1:0] m_data,
    output logic             busy
`ifdef MIMO_SEQ_STATS_EN
    ,
    output logic [15:0]      vec_total,
    output logic [15:0]      stall_cycles
`endif
);

    localparam int unsigned DW    = 8 * W_L;
    localparam int unsigned OW    = 8 * W_O;
    localparam int unsigned LAT_W = $clog2(DEC_LAT);
    localparam int unsigned VEC_W = $clog2(NUM_VEC + 1);

    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(DEC_LAT - 1);
    localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(NUM_VEC - 1);
    localparam logic [1:0]       ROW_LAST = 2'(CH_ROWS - 1);

    seq_state_t       state_q, state_d;
    logic [1:0]       row_cnt_q, row_cnt_d;
    logic [1:0]       burst_cnt_q, burst_cnt_d;
    logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
    logic [VEC_W-1:0] vec_cnt_q, vec_cnt_d;
    logic             dec_flag_q, dec_flag_d;
    logic [DW-1:0]    dec_data_q, dec_data_d;
    logic             m_valid_q, m_valid_d;
    logic [OW-1:0]    m_data_q, m_data_d;

    logic             s_hs_c;
    logic             ch_we_c;
    logic             capture_c;
    logic [1:0]       ch_raddr_c;
    logic [DW-1:0]    ch_rdata_c;

    // DATA_WAIT only accepts when the output register is free at capture time.
    always_comb begin
        s_ready = 1'b0;
        case (state_q)
            CH_FILL:   s_ready = 1'b1;
            DATA_WAIT: s_ready = !m_valid_q || m_ready;
            default:   s_ready = 1'b0;
        endcase
    end

    assign busy   = !((state_q == DATA_WAIT) && (vec_cnt_q == '0));
    assign s_hs_c = s_valid && s_ready;

    // Row 0 is presented on burst entry, so each burst cycle prefetches the next row.
    assign ch_raddr_c = (state_q == CH_BURST) ? burst_cnt_q + 2'd1 : 2'd0;

    mimo_ch_buf #(
        .DW (DW)
    ) u_ch_buf (
        .clk     (clk),
        .rst     (rst),
        .we      (ch_we_c),
        .waddr   (row_cnt_q),
        .wdata   (s_data),
        .raddr   (ch_raddr_c),
        .rdata_c (ch_rdata_c)
    );

    always_comb begin
        state_d     = state_q;
        row_cnt_d   = row_cnt_q;
        burst_cnt_d = burst_cnt_q;
        lat_cnt_d   = lat_cnt_q;
        vec_cnt_d   = vec_cnt_q;
        dec_flag_d  = dec_flag_q;
        dec_data_d  = dec_data_q;
        ch_we_c     = 1'b0;
        capture_c   = 1'b0;

        case (state_q)
            CH_FILL: begin
                if (s_hs_c) begin
                    ch_we_c   = 1'b1;
                    row_cnt_d = row_cnt_q + 2'd1;
                    if (row_cnt_q == ROW_LAST) begin
                        state_d     = CH_BURST;
                        burst_cnt_d = 2'd0;
                        dec_flag_d  = 1'b1;
                        dec_data_d  = ch_rdata_c;
                    end
                end
            end
            CH_BURST: begin
                burst_cnt_d = burst_cnt_q + 2'd1;
                if (burst_cnt_q == ROW_LAST) begin
                    state_d   = DATA_WAIT;
                    vec_cnt_d = '0;
                end else begin
                    dec_data_d = ch_rdata_c;
                end
            end
            DATA_WAIT: begin
                if (s_hs_c) begin
                    state_d    = DATA_RUN;
                    dec_data_d = s_data;
                    dec_flag_d = 1'b0;
                    lat_cnt_d  = '0;
                end
            end
            DATA_RUN: begin
                lat_cnt_d = lat_cnt_q + LAT_W'(1);
                if (lat_cnt_q == LAT_LAST) begin
                    capture_c = 1'b1;
                    vec_cnt_d = vec_cnt_q + VEC_W'(1);
                    if (vec_cnt_q == VEC_LAST) begin
                        state_d   = CH_FILL;
                        row_cnt_d = 2'd0;
                    end else begin
                        state_d = DATA_WAIT;
                    end
                end
            end
            default: state_d = CH_FILL;
        endcase
    end

    // Capture takes priority over a downstream pop in the same cycle.
    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        if (capture_c) begin
            m_valid_d = 1'b1;
            m_data_d  = dec_out;
        end else if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= CH_FILL;
            row_cnt_q   <= '0;
            burst_cnt_q <= '0;
            lat_cnt_q   <= '0;
            vec_cnt_q   <= '0;
            dec_flag_q  <= 1'b1;
            dec_data_q  <= '0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            lat_cnt_q   <= lat_cnt_d;
            vec_cnt_q   <= vec_cnt_d;
            dec_flag_q  <= dec_flag_d;
            dec_data_q  <= dec_data_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
        end
    end

    assign dec_flag = dec_flag_q;
    assign dec_data = dec_data_q;
    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;

`ifdef MIMO_SEQ_STATS_EN
    logic [15:0] vec_total_q, vec_total_d;
    logic [15:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        vec_total_d    = vec_total_q;
        stall_cycles_d = stall_cycles_q;
        if (capture_c && (vec_total_q != 16'hFFFF)) begin
            vec_total_d = vec_total_q + 16'd1;
        end
        if ((state_q == DATA_WAIT) && s_valid && !s_ready && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vec_total_q    <= '0;
            stall_cycles_q <= '0;
        end else begin
            vec_total_q    <= vec_total_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign vec_total    = vec_total_q;
    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_mimo_decode_sequencer.sv
// Randomized self-checking bench for mimo_decode_sequencer (DEC_LAT=36, NUM_VEC=2).
module tb_mimo_decode_sequencer;

    localparam int unsigned WL = 15;
    localparam int unsigned WO = 15;
    localparam int unsigned DL = 36;
    localparam int unsigned NV = 2;
    localparam int unsigned DW = 8 * WL;
    localparam int unsigned OW = 8 * WO;

    logic          clk;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          dec_flag;
    logic [DW-1:0] dec_data;
    logic [OW-1:0] dec_out;
    logic          m_valid;
    logic          m_ready;
    logic [OW-1:0] m_data;
    logic          busy;
`ifdef MIMO_SEQ_STATS_EN
    logic [15:0]   vec_total;
    logic [15:0]   stall_cycles;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state: channel rows of the current frame, frame position, stats.
    logic [DW-1:0] rows [4];
    int            vec_in_frame = 0;
    int            exp_vec_total = 0;
    int            exp_stall = 0;

    mimo_decode_sequencer #(
        .W_L     (WL),
        .W_O     (WO),
        .DEC_LAT (DL),
        .NUM_VEC (NV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .dec_flag (dec_flag),
        .dec_data (dec_data),
        .dec_out  (dec_out),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .busy     (busy)
`ifdef MIMO_SEQ_STATS_EN
        ,
        .vec_total    (vec_total),
        .stall_cycles (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] rand128();
        logic [127:0] r;
        for (int i = 0; i < 4; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Feeds four random channel rows; returns at the sample point after the 4th accepting edge.
    task automatic load_channel(input bit gap);
        logic [127:0] t;
        bit acc;
        for (int k = 0; k < 4; k++) begin
            t = rand128();
            rows[k] = t[DW-1:0];
            s_valid = 1'b1;
            s_data  = rows[k];
            acc = 1'b0;
            for (int n = 0; n < 20 && !acc; n++) begin
                acc = s_ready;
                tick();
            end
            checks++;
            if (!acc) begin
                errors++;
                $display("FAIL chan_accept row %0d: s_ready got 0 for 20 cycles, expected 1", k);
            end
            if (gap && k < 3) begin
                s_valid = 1'b0;
                tick();
            end
        end
        s_valid = 1'b0;
    endtask

    // Expects the four rows on consecutive cycles with flag high, then DATA_WAIT with vec_cnt 0.
    task automatic check_burst();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (dec_flag !== 1'b1) begin
                errors++; $display("FAIL burst_flag row %0d: got %b expected 1", k, dec_flag);
            end
            checks++;
            if (dec_data !== rows[k]) begin
                errors++; $display("FAIL burst_data row %0d: got %h expected %h", k, dec_data, rows[k]);
            end
            checks++;
            if (s_ready !== 1'b0) begin
                errors++; $display("FAIL burst_s_ready row %0d: got %b expected 0", k, s_ready);
            end
            tick();
        end
        checks++;
        if (s_ready !== 1'b1) begin
            errors++; $display("FAIL burst_end_ready: got %b expected 1", s_ready);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL burst_end_busy: got %b expected 0", busy);
        end
    endtask

    task automatic send_vector(input logic [DW-1:0] v, output int edges);
        bit acc;
        s_valid = 1'b1;
        s_data  = v;
        acc = 1'b0;
        edges = 0;
        for (int n = 0; n < 100 && !acc; n++) begin
            acc = s_ready;
            tick();
            edges++;
        end
        s_valid = 1'b0;
        checks++;
        if (!acc) begin
            errors++; $display("FAIL vec_accept: s_ready got 0 for 100 cycles, expected 1");
        end
    endtask

    // Holds for the decode latency with a random core output; checks capture and frame progress.
    task automatic run_latency(input logic [DW-1:0] v, output logic [OW-1:0] out);
        logic [127:0] t;
        out = '0;
        for (int k = 1; k <= int'(DL); k++) begin
            checks++;
            if (dec_data !== v) begin
                errors++; $display("FAIL hold_data cyc %0d: got %h expected %h", k, dec_data, v);
            end
            checks++;
            if (dec_flag !== 1'b0) begin
                errors++; $display("FAIL hold_flag cyc %0d: got %b expected 0", k, dec_flag);
            end
            checks++;
            if (s_ready !== 1'b0) begin
                errors++; $display("FAIL hold_s_ready cyc %0d: got %b expected 0", k, s_ready);
            end
            checks++;
            if (m_valid !== 1'b0) begin
                errors++; $display("FAIL early_m_valid cyc %0d: got %b expected 0", k, m_valid);
            end
            t = rand128();
            dec_out = t[OW-1:0];
            out = dec_out;
            tick();
        end
        checks++;
        if (m_valid !== 1'b1) begin
            errors++; $display("FAIL capture_m_valid: got %b expected 1", m_valid);
        end
        checks++;
        if (m_data !== out) begin
            errors++; $display("FAIL capture_m_data: got %h expected %h", m_data, out);
        end
        vec_in_frame++;
        exp_vec_total++;
        if (vec_in_frame == int'(NV)) begin
            vec_in_frame = 0;
            checks++;
            if (s_ready !== 1'b1 || busy !== 1'b1) begin
                errors++; $display("FAIL frame_end: s_ready/busy got %b%b expected 11", s_ready, busy);
            end
        end else begin
            checks++;
            if (busy !== 1'b1 || s_ready !== m_ready) begin
                errors++; $display("FAIL mid_frame: s_ready/busy got %b%b expected %b1", s_ready, busy, m_ready);
            end
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if (s_ready !== 1'b1 || busy !== 1'b1 || dec_flag !== 1'b1 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: s_ready,busy,dec_flag,m_valid got %b%b%b%b expected 1110",
                     s_ready, busy, dec_flag, m_valid);
        end
        checks++;
        if (dec_data !== '0 || m_data !== '0) begin
            errors++; $display("FAIL reset_data: dec_data %h m_data %h expected 0", dec_data, m_data);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (s_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release_ready: got %b expected 1", s_ready);
        end
    endtask

    task automatic test_channel_burst();
        load_channel(1'b0);
        check_burst();
    endtask

    task automatic test_data_path();
        logic [127:0] t;
        logic [DW-1:0] v;
        logic [OW-1:0] o;
        int e;
        m_ready = 1'b1;
        for (int i = 0; i < int'(NV); i++) begin
            t = rand128();
            v = t[DW-1:0];
            send_vector(v, e);
            checks++;
            if (e != 1) begin
                errors++; $display("FAIL throughput vec %0d: accept after %0d edges expected 1", i, e);
            end
            run_latency(v, o);
        end
    endtask

    task automatic test_channel_gaps();
        logic [127:0] t;
        logic [DW-1:0] v;
        logic [OW-1:0] o;
        int e;
        load_channel(1'b1);
        t = rand128();
        v = t[DW-1:0];
        s_valid = 1'b1;
        s_data  = v;
        check_burst();
        send_vector(v, e);
        checks++;
        if (e != 1) begin
            errors++; $display("FAIL first_data_accept: after %0d edges expected 1", e);
        end
        run_latency(v, o);
        t = rand128();
        v = t[DW-1:0];
        send_vector(v, e);
        run_latency(v, o);
    endtask

    task automatic test_reset_mid_run();
        logic [127:0] t;
        logic [DW-1:0] v;
        int e;
        load_channel(1'b0);
        for (int i = 0; i < 4; i++) tick();
        t = rand128();
        v = t[DW-1:0];
        send_vector(v, e);
        for (int i = 0; i < 20; i++) tick();
        rst = 1'b0;
        #1;
        checks++;
        if (m_valid !== 1'b0 || dec_flag !== 1'b1) begin
            errors++; $display("FAIL midrst_out: m_valid,dec_flag got %b%b expected 01", m_valid, dec_flag);
        end
        checks++;
        if (dec_data !== '0 || s_ready !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL midrst_state: dec_data %h s_ready %b busy %b expected 0,1,1",
                               dec_data, s_ready, busy);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        vec_in_frame  = 0;
        exp_vec_total = 0;
        exp_stall     = 0;
        load_channel(1'b0);
        check_burst();
    endtask

    task automatic test_backpressure();
        logic [127:0] t;
        logic [DW-1:0] va, vb, vc;
        logic [OW-1:0] oa, ob, oc;
        int e;
        t = rand128(); va = t[DW-1:0];
        t = rand128(); vb = t[DW-1:0];
        t = rand128(); vc = t[DW-1:0];
        m_ready = 1'b0;
        send_vector(va, e);
        run_latency(va, oa);
        s_valid = 1'b1;
        s_data  = vb;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (s_ready !== 1'b0) begin
                errors++; $display("FAIL stall_ready cyc %0d: got %b expected 0", i, s_ready);
            end
            tick();
            exp_stall++;
            checks++;
            if (m_valid !== 1'b1 || m_data !== oa) begin
                errors++; $display("FAIL stall_hold cyc %0d: m_valid %b m_data %h expected 1 %h",
                                   i, m_valid, m_data, oa);
            end
        end
        m_ready = 1'b1;
        #1;
        checks++;
        if (s_ready !== 1'b1) begin
            errors++; $display("FAIL release_ready: got %b expected 1", s_ready);
        end
        tick();
        s_valid = 1'b0;
        checks++;
        if (m_valid !== 1'b0 || dec_data !== vb) begin
            errors++; $display("FAIL release_accept: m_valid %b dec_data %h expected 0 %h", m_valid, dec_data, vb);
        end
        run_latency(vb, ob);
        load_channel(1'b0);
        check_burst();
        send_vector(vc, e);
        run_latency(vc, oc);
        tick();
        checks++;
        if (m_valid !== 1'b0) begin
            errors++; $display("FAIL pop_clear: m_valid got %b expected 0", m_valid);
        end
`ifdef MIMO_SEQ_STATS_EN
        checks++;
        if (vec_total !== 16'(exp_vec_total)) begin
            errors++; $display("FAIL stats_vec_total: got %0d expected %0d", vec_total, exp_vec_total);
        end
        checks++;
        if (stall_cycles !== 16'(exp_stall)) begin
            errors++; $display("FAIL stats_stall: got %0d expected %0d", stall_cycles, exp_stall);
        end
`endif
    endtask

    initial begin
        rst     = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        dec_out = '0;
        m_ready = 1'b0;
        test_reset();
        test_channel_burst();
        test_data_path();
        test_channel_gaps();
        test_reset_mid_run();
        test_backpressure();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
